// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and helpers for the multi-port register file.
//   state_t     : INIT (reset walk in progress) / RUN (normal operation)
//   addr_width  : register address width for a given register count
//   init_value  : value loaded into register idx during the reset walk
package regfile_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Widest data path the init helper supports; callers truncate to XLEN.
  localparam int MAX_XLEN = 64;

  function automatic int addr_width(input int nregs);
    return (nregs < 2) ? 1 : $clog2(nregs);
  endfunction

  // mode 0: all registers start at zero; mode 1: register i starts at i.
  function automatic logic [MAX_XLEN-1:0] init_value(input int mode, input int idx);
    return (mode == 1) ? MAX_XLEN'(idx) : '0;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: one busy bit per register.
//   clk, reset          : clock, synchronous active-high clear of all bits
//   set_en, set_addr    : mark a register busy (destination reserved at issue)
//   clr_en, clr_addr    : clear a register's busy bit (writeback)
//   lookup_addr/busy    : NREAD combinational lookups, packed AW bits per port
// Register 0 never holds a busy bit. When set and clear hit the same register
// in one cycle the set wins: the newly issued producer is still outstanding.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  parameter int AW    = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                set_en,
  input  logic [AW-1:0]       set_addr,
  input  logic                clr_en,
  input  logic [AW-1:0]       clr_addr,
  input  logic [NREAD*AW-1:0] lookup_addr,
  output logic [NREAD-1:0]    lookup_busy
);

  logic [NREGS-1:0] busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      if (clr_en) busy[clr_addr] <= 1'b0;
      if (set_en) busy[set_addr] <= 1'b1;
      busy[0] <= 1'b0;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_lookup
    assign lookup_busy[k] = busy[lookup_addr[k*AW +: AW]];
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port register file with a pending-write
// scoreboard and a sequenced initialisation walk after reset.
//   clk, reset : clock, synchronous active-high reset
//   ready      : high once every register has been initialised
//   rd_addr    : NREAD packed read addresses (port k at [k*AW +: AW])
//   rd_data    : NREAD packed read data (port k at [k*XLEN +: XLEN])
//   rd_busy    : per port, addressed register awaits a reserved result
//   rsv_en/rsv_addr                : reserve a destination (sets busy)
//   wr_en/wr_addr/wr_data          : writeback (writes data, clears busy)
// Handshake: there is no backpressure. rsv_en and wr_en are single-cycle
// qualifiers accepted on any edge where ready is high and ignored otherwise;
// reads are combinational and valid whenever ready is high (zero before).
// Register 0 reads as zero, is never busy and ignores writes and reserves.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int NREAD     = 2,
  parameter int BYPASS    = 1,
  parameter int INIT_MODE = 0,
  localparam int AW       = addr_width(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  ready,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  rsv_en,
  input  logic [AW-1:0]         rsv_addr,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data
);

  state_t          state;
  logic [AW-1:0]   walk;
  logic [XLEN-1:0] regs [NREGS];

  // Walk FSM: one register initialised per cycle, RUN after the last one.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_INIT;
      walk  <= '0;
    end else if (state == ST_INIT) begin
      walk <= walk + AW'(1);
      if (walk == AW'(NREGS - 1)) state <= ST_RUN;
    end
  end

  assign ready = (state == ST_RUN);

  // Single array write port shared by the init walk and writeback.
  logic            arr_we;
  logic [AW-1:0]   arr_waddr;
  logic [XLEN-1:0] arr_wdata;

  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = walk;
    arr_wdata = XLEN'(init_value(INIT_MODE, int'(walk)));
    if (!reset) begin
      if (state == ST_INIT) begin
        arr_we = 1'b1;
      end else if (wr_en && (wr_addr != '0)) begin
        arr_we    = 1'b1;
        arr_waddr = wr_addr;
        arr_wdata = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (arr_we) regs[arr_waddr] <= arr_wdata;
  end

  // Scoreboard updates only take effect once initialisation is complete.
  logic             sb_set;
  logic             sb_clr;
  logic [NREAD-1:0] sb_busy;

  assign sb_set = ready && rsv_en && (rsv_addr != '0);
  assign sb_clr = ready && wr_en  && (wr_addr  != '0);

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NREAD (NREAD),
    .AW    (AW)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .set_en      (sb_set),
    .set_addr    (rsv_addr),
    .clr_en      (sb_clr),
    .clr_addr    (wr_addr),
    .lookup_addr (rd_addr),
    .lookup_busy (sb_busy)
  );

  // Read ports. A bypass hit returns the in-flight writeback data and reports
  // not-busy; a reservation landing in the same cycle shows up next cycle.
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic          hit;

    assign a   = rd_addr[k*AW +: AW];
    assign hit = (BYPASS != 0) && wr_en && (wr_addr == a);

    assign rd_data[k*XLEN +: XLEN] = (!ready || (a == '0)) ? '0 :
                                     hit                   ? wr_data :
                                                             regs[a];
    assign rd_busy[k] = ready && (a != '0) && !hit && sb_busy[k];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances share all stimulus, one with bypass
// and register-index init values, one without bypass and zero init.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NREAD = 4;
  localparam int AW    = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset;
  logic                  ready_a, ready_b;
  logic [NREAD*AW-1:0]   rd_addr;
  logic [NREAD*XLEN-1:0] rd_data_a, rd_data_b;
  logic [NREAD-1:0]      rd_busy_a, rd_busy_b;
  logic                  rsv_en;
  logic [AW-1:0]         rsv_addr;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [XLEN-1:0]       wr_data;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(1), .INIT_MODE(1)) dut_a (
    .clk(clk), .reset(reset), .ready(ready_a), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_busy(rd_busy_a), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data));

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(0), .INIT_MODE(0)) dut_b (
    .clk(clk), .reset(reset), .ready(ready_b), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data));

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [XLEN-1:0] m_regs_a [NREGS];
  logic [XLEN-1:0] m_regs_b [NREGS];
  bit              m_busy   [NREGS];
  bit              m_ready;
  int              m_walk;

  // Apply the architectural effect of the coming clock edge.
  task automatic model_edge();
    if (reset) begin
      m_ready = 0;
      m_walk  = 0;
      foreach (m_busy[i]) m_busy[i] = 0;
    end else if (!m_ready) begin
      m_regs_a[m_walk] = m_walk;
      m_regs_b[m_walk] = 0;
      m_walk++;
      if (m_walk == NREGS) m_ready = 1;
    end else begin
      if (wr_en && wr_addr != 0) begin
        m_regs_a[wr_addr] = wr_data;
        m_regs_b[wr_addr] = wr_data;
        m_busy[wr_addr]   = 0;
      end
      if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1;
    end
  endtask

  function automatic logic [31:0] exp_data(input bit byp, input bit inst_a, input int addr);
    if (!m_ready || addr == 0) return 0;
    if (byp && wr_en && int'(wr_addr) == addr) return wr_data;
    return inst_a ? m_regs_a[addr] : m_regs_b[addr];
  endfunction

  function automatic bit exp_busy(input bit byp, input int addr);
    if (!m_ready || addr == 0) return 0;
    if (byp && wr_en && int'(wr_addr) == addr) return 0;
    return m_busy[addr];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int a0, input int a1, input int a2, input int a3);
    rd_addr = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    #1;
  endtask

  task automatic idle();
    wr_en = 0; rsv_en = 0; wr_addr = 0; rsv_addr = 0; wr_data = 0;
  endtask

  task automatic check_all(input string tag);
    int a;
    check($sformatf("%s ready_a", tag), ready_a, m_ready);
    check($sformatf("%s ready_b", tag), ready_b, m_ready);
    for (int k = 0; k < NREAD; k++) begin
      a = int'(rd_addr[k*AW +: AW]);
      check($sformatf("%s a.data[%0d] r%0d", tag, k, a), rd_data_a[k*XLEN +: XLEN], exp_data(1, 1, a));
      check($sformatf("%s a.busy[%0d] r%0d", tag, k, a), rd_busy_a[k], exp_busy(1, a));
      check($sformatf("%s b.data[%0d] r%0d", tag, k, a), rd_data_b[k*XLEN +: XLEN], exp_data(0, 0, a));
      check($sformatf("%s b.busy[%0d] r%0d", tag, k, a), rd_busy_b[k], exp_busy(0, a));
    end
  endtask

  // Step until ready (bounded); returns edges counted since reset release.
  task automatic run_init(input string tag, output int edges);
    edges = 0;
    while (edges < 100 && ready_a !== 1'b1) begin
      tick();
      edges++;
      check_all(tag);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    bit          rsv_en;
    logic [4:0]  rsv_addr;
    logic [4:0]  rd;
    logic [31:0] a_data;
    bit          a_busy;
    logic [31:0] b_data;
    bit          b_busy;
  } vec_t;

  vec_t vt [15];

  initial begin
    int edges;

    vt[0]  = '{1'b1, 5'd3,  32'hDEADBEEF, 1'b0, 5'd0, 5'd3,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
    vt[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd3,  32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 5'd7,  32'h7,        1'b0, 32'h0,        1'b0};
    vt[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd7,  32'h7,        1'b1, 32'h0,        1'b1};
    vt[4]  = '{1'b1, 5'd7,  32'h1234,     1'b0, 5'd0, 5'd7,  32'h1234,     1'b0, 32'h0,        1'b1};
    vt[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd7,  32'h1234,     1'b0, 32'h1234,     1'b0};
    vt[6]  = '{1'b1, 5'd9,  32'hAAAA5555, 1'b1, 5'd9, 5'd9,  32'hAAAA5555, 1'b0, 32'h0,        1'b0};
    vt[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd9,  32'hAAAA5555, 1'b1, 32'hAAAA5555, 1'b1};
    vt[8]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0};
    vt[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0};
    vt[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd5,  32'h5,        1'b0, 32'h0,        1'b0};
    vt[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd31, 32'h1F,       1'b0, 32'h0,        1'b0};
    vt[12] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9, 5'd9,  32'hAAAA5555, 1'b1, 32'hAAAA5555, 1'b1};
    vt[13] = '{1'b1, 5'd9,  32'h1,        1'b0, 5'd0, 5'd9,  32'h1,        1'b0, 32'hAAAA5555, 1'b1};
    vt[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd9,  32'h1,        1'b0, 32'h1,        1'b0};

    // Reset, then initialise with writes and reserves held high (ignored).
    reset = 1; idle(); set_rd(0, 0, 0, 0);
    tick();
    reset = 0;
    wr_en = 1; wr_addr = 4; wr_data = 32'hCAFEF00D; rsv_en = 1; rsv_addr = 6;
    set_rd(4, 6, 5, 31);
    check_all("reset");
    check("reset ready", ready_a, 1'b0);
    run_init("init1", edges);
    check("init1 edges to ready", edges, NREGS);
    idle(); set_rd(5, 31, 0, 4);
    check("init1 r5", rd_data_a[31:0], 32'h5);
    check("init1 r31", rd_data_a[63:32], 32'h1F);
    check("init1 r0", rd_data_a[95:64], 32'h0);
    check("init1 r4 untouched", rd_data_a[127:96], 32'h4);
    set_rd(6, 6, 4, 4);
    check("init1 r6 not busy", rd_busy_a[0], 1'b0);
    check("init1 b r4 zero", rd_data_b[127:96], 32'h0);
    check_all("init1 done");

    // Reset again, abort the walk at counter 10, then restart it.
    reset = 1; tick();
    reset = 0;
    for (int i = 0; i < 10; i++) begin tick(); check_all("walk10"); end
    reset = 1; tick();
    reset = 0;
    wr_en = 1; wr_addr = 11; wr_data = 32'h55AA55AA;
    set_rd(11, 10, 3, 0);
    run_init("init2", edges);
    check("init2 edges to ready", edges, NREGS);
    idle(); set_rd(11, 10, 3, 0);
    check("init2 r11", rd_data_a[31:0], 32'hB);
    check("init2 r10", rd_data_a[63:32], 32'hA);
    check_all("init2 done");

    // Directed table.
    for (int i = 0; i < 15; i++) begin
      wr_en = vt[i].wr_en; wr_addr = vt[i].wr_addr; wr_data = vt[i].wr_data;
      rsv_en = vt[i].rsv_en; rsv_addr = vt[i].rsv_addr;
      set_rd(vt[i].rd, vt[i].rd, vt[i].rd ^ 5'd1, $urandom_range(0, NREGS - 1));
      for (int k = 0; k < 2; k++) begin
        check($sformatf("vec%0d a.data[%0d]", i, k), rd_data_a[k*XLEN +: XLEN], vt[i].a_data);
        check($sformatf("vec%0d a.busy[%0d]", i, k), rd_busy_a[k], vt[i].a_busy);
        check($sformatf("vec%0d b.data[%0d]", i, k), rd_data_b[k*XLEN +: XLEN], vt[i].b_data);
        check($sformatf("vec%0d b.busy[%0d]", i, k), rd_busy_b[k], vt[i].b_busy);
      end
      check_all($sformatf("vec%0d", i));
      tick();
    end

    // Randomised traffic against the model, with one mid-run reset.
    for (int i = 0; i < 400; i++) begin
      int hot;
      hot = $urandom_range(0, 1);
      reset = (i == 200);
      wr_en = $urandom_range(0, 1);
      wr_addr = hot ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREGS - 1));
      wr_data = $urandom;
      rsv_en = $urandom_range(0, 1);
      rsv_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, 7));
      set_rd(($urandom_range(0, 2) == 0) ? int'(wr_addr) : $urandom_range(0, 7),
             $urandom_range(0, NREGS - 1),
             ($urandom_range(0, 1) == 0) ? int'(rsv_addr) : $urandom_range(0, 7),
             ($urandom_range(0, 1) == 0) ? int'(wr_addr) : $urandom_range(0, 3));
      check_all($sformatf("rnd%0d", i));
      tick();
    end
    reset = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
